demux_s: RTL and testbench
==========================

# demux_s

Registered 1-to-N demultiplexer. A single data input `q` is routed to the output lane chosen by `select`, and every other lane is driven to zero. The block sits between a shared serial or narrow source and N per-destination consumers. The default configuration is the 1-to-8, 1-bit demux, with lanes packed into the 8-bit bus `d`.

## Interface
Parameters:
- `SEL_W`, default 3: width of `select`. Lane count is N = 2**SEL_W (derived, not overridable).
- `DW`, default 1: width of one data lane, which is also the width of `q`.

Ports:
- `clk`  input  1: single clock. All state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low. Asserting it clears `d` immediately; release is synchronous to `clk`.
- `select`  input  SEL_W: lane index, 0 to N-1.
- `q`  input  DW: data to route.
- `d`  output  N*DW: lane bus. Lane k occupies bits [k*DW +: DW], with lane 0 at the LSBs.

Connect ports by name.

## Operation
- On each rising `clk` edge with `rst_n`=1:
  - Lane `select` of `d` is loaded with `q`.
  - Every other lane is loaded with all zeros.
- Exactly one lane can be non-zero at any time. `d` is zero whenever `q`=0, whatever `select` is.
- Every `select` encoding is a valid lane, because N = 2**SEL_W. There is no out-of-range case and no error output.
- No enable input: `select` and `q` are sampled on every edge.
- Default config truth table, one cycle after sampling, with q=1:
  - select 0 gives d=00000001.
  - select 1 gives d=00000010.
  - This pattern continues through select 7, which gives d=10000000.
  - With q=0, d=00000000 for every select.
- X/Z on `select` or `q` is not handled specially. Behaviour in that case is whatever the RTL semantics produce, and benches must not drive X/Z after reset.

## Timing
- Latency is 1 clock. Inputs sampled at edge n appear on `d` after edge n and hold until edge n+1.
- Throughput is one new `select`/`q` pair per cycle. Back-to-back changes are required to work with no bubbles.
- Input changes between edges have no effect on `d`. The output is purely registered and has no combinational path from inputs to `d`.
- Reset value: `d` = 0 (all N*DW bits).
- Asserting `rst_n` mid-operation forces `d` to 0 asynchronously, without waiting for a clock edge. `d` stays 0 while `rst_n` is low, even if clock edges occur.
- First edge after `rst_n` rises: inputs are sampled normally. `d` reflects them one cycle later, so there is no extra recovery cycle.
- When `select` changes, the old lane clears and the new lane loads on the same edge. No intermediate state with two active lanes is ever visible.

## Test plan
- **Reset:** drive select=5, q=1 and hold `rst_n`=0 across several edges. Required: `d`=00000000 throughout. After releasing reset, `d`=00100000 after the next edge.
- **Full sweep, q=1:** step select through 0 to 7, one value per cycle, and repeat the loop 3 times. Required: `d` walks 00000001, 00000010, …, 10000000 with 1-cycle lag. The sequence is identical on each pass, and a single 1 is present every cycle.
- **q=0:** sweep select through 0 to 7. Required: `d`=00000000 every cycle.
- **Async reset mid-sweep:** drop `rst_n` between edges while select=3, q=1. Required: `d` goes from 00001000 to 00000000 before the next edge, and stays 0 until after reset release plus one edge.
- **Inter-edge glitch:** toggle select 2→6→2 between two edges. Required: `d` is unchanged until the edge, then shows lane 2 only (00000100).
- **DW=4, SEL_W=2 config:** select=2, q=4'hA. Required: `d`=16'h0A00. Then select=0, q=4'hF gives `d`=16'h000F.

Source files
------------

// File: rtl/demux_s.sv
// Registered 1-to-2**SEL_W demux: q lands on lane `select`, all other lanes are zero.
// Latency 1 clk, one pair per cycle; no backpressure, so inputs are sampled on every edge.
module demux_s #(
  parameter  int SEL_W = 3,
  parameter  int DW    = 1,
  localparam int N     = 2**SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  select,
  input  logic [DW-1:0]     q,
  output logic [N*DW-1:0]   d
);

  logic [N*DW-1:0] d_nxt;

  // Full lane decode: the old lane clears and the new one loads on the same edge.
  always_comb begin
    d_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (select == SEL_W'(k)) begin
        d_nxt[k*DW +: DW] = q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
    end else begin
      d <= d_nxt;
    end
  end

endmodule

// File: tb/tb_demux_s.sv
// Bench for demux_s: default 1-to-8 x 1-bit instance plus a 1-to-4 x 4-bit instance.
module tb_demux_s;

  logic        clk;
  logic        rst_n;
  logic [2:0]  select;
  logic        q;
  logic [7:0]  d;
  logic [1:0]  select_w;
  logic [3:0]  q_w;
  logic [15:0] d_w;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  exp_q  [$];
  logic [15:0] exp_wq [$];

  typedef struct {
    logic [2:0] sel;
    logic       qv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [32];

  demux_s #(.SEL_W(3), .DW(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .select (select),
    .q      (q),
    .d      (d)
  );

  demux_s #(.SEL_W(2), .DW(4)) dut_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .select (select_w),
    .q      (q_w),
    .d      (d_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Drive one pair mid-cycle, push its expectation, check it after the next edge.
  task automatic step8(input string nm, input logic [2:0] s, input logic qv, input logic [7:0] exp);
    select = s;
    q      = qv;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk8(nm, d, exp_q.pop_front());
  endtask

  task automatic step16(input string nm, input logic [1:0] s, input logic [3:0] qv,
                        input logic [15:0] exp);
    select_w = s;
    q_w      = qv;
    exp_wq.push_back(exp);
    @(posedge clk);
    #1;
    chk16(nm, d_w, exp_wq.pop_front());
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        tbl[p*8+i].sel = 3'(i);
        tbl[p*8+i].qv  = 1'b1;
        tbl[p*8+i].exp = 8'h01 << i;
      end
    end
    for (int i = 0; i < 8; i++) begin
      tbl[24+i].sel = 3'(7 - i);
      tbl[24+i].qv  = 1'b0;
      tbl[24+i].exp = 8'h00;
    end

    // Reset held across edges with a live lane selected.
    rst_n    = 1'b0;
    select   = 3'd5;
    q        = 1'b1;
    select_w = 2'd0;
    q_w      = 4'h0;
    #1;
    chk8("reset_initial", d, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk8("reset_held", d, 8'h00);
    end
    rst_n = 1'b1;
    #1;
    chk8("reset_release_pre_edge", d, 8'h00);
    step8("reset_first_edge", 3'd5, 1'b1, 8'b0010_0000);

    // Sweep table: q=1 three passes, then q=0.
    for (int i = 0; i < 32; i++) begin
      step8($sformatf("table[%0d]", i), tbl[i].sel, tbl[i].qv, tbl[i].exp);
      if (tbl[i].qv) begin
        n_chk++;
        if ($onehot(d)) n_pass++;
        else $display("FAIL onehot[%0d]: got %b want a single 1", i, d);
      end
    end

    // Async reset mid-sweep.
    step8("async_pre", 3'd3, 1'b1, 8'b0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async_immediate", d, 8'h00);
    @(posedge clk);
    #1;
    chk8("async_held_edge", d, 8'h00);
    rst_n = 1'b1;
    #1;
    chk8("async_release_pre_edge", d, 8'h00);
    step8("async_recover", 3'd3, 1'b1, 8'b0000_1000);

    // Inter-edge select glitch.
    step8("glitch_pre", 3'd0, 1'b1, 8'b0000_0001);
    select = 3'd2;
    #1;
    chk8("glitch_sel2", d, 8'b0000_0001);
    select = 3'd6;
    #1;
    chk8("glitch_sel6", d, 8'b0000_0001);
    step8("glitch_edge", 3'd2, 1'b1, 8'b0000_0100);

    // Back-to-back lane switch.
    step8("b2b_a", 3'd7, 1'b1, 8'b1000_0000);
    step8("b2b_b", 3'd1, 1'b1, 8'b0000_0010);

    // Wide configuration.
    step16("wide_sel2_A", 2'd2, 4'hA, 16'h0A00);
    step16("wide_sel0_F", 2'd0, 4'hF, 16'h000F);
    step16("wide_sel3_5", 2'd3, 4'h5, 16'h5000);
    step16("wide_q0",     2'd1, 4'h0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
